// File: rtl/flash_rom_loader_pkg.sv
// Shared types for the boot-time flash-to-SRAM loader.
package common;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_WRITE, ST_FINISH} loader_state_t;
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
endpackage

// File: rtl/flash_rom_loader_shifter.sv
// SPI mode-0 shifter at clk/2: 32-bit command out on MOSI, bytes in from MISO.
module spi_byte_shifter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        tx_en_i,
    input  logic        miso_i,
    output logic        sck_o,
    output logic        mosi_o,
    output logic        bit_done_o,
    output logic [7:0]  rx_byte_o
);
    logic        ph_q, ph_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q   <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            ph_q   <= ph_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

    // ph_q=0: SCK low half, MOSI changes; ph_q=1: rising edge, MISO captured.
    always_comb begin
        ph_d   = ph_q;
        sck_d  = sck_q;
        mosi_d = mosi_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        if (load_i) begin
            tx_d   = load_data_i;
            ph_d   = 1'b0;
            sck_d  = 1'b0;
            mosi_d = 1'b0;
        end else if (en_i) begin
            if (!ph_q) begin
                sck_d  = 1'b0;
                mosi_d = tx_en_i & tx_q[31];
                tx_d   = {tx_q[30:0], 1'b0};
                ph_d   = 1'b1;
            end else begin
                sck_d = 1'b1;
                ph_d  = 1'b0;
                rx_d  = {rx_q[6:0], miso_i};
            end
        end else begin
            sck_d  = 1'b0;
            mosi_d = 1'b0;
            ph_d   = 1'b0;
        end
    end

    assign sck_o      = sck_q;
    assign mosi_o     = mosi_q;
    assign bit_done_o = en_i & ph_q;
    assign rx_byte_o  = {rx_q[6:0], miso_i};
endmodule

// File: rtl/flash_rom_loader.sv
// Streams LENGTH bytes from SPI flash at ROM_OFFSET into SRAM 0..LENGTH-1 after init.
module flash_rom_loader
    import common::*;
#(
    parameter logic [23:0] ROM_OFFSET = 24'h13256,
    parameter logic [17:0] LENGTH     = 18'h20000,
    parameter int unsigned WR_CYCLES  = 4
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        init,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic [16:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0]  WRC      = 4'(WR_CYCLES);
    localparam logic [3:0]  WR_END   = 4'(WR_CYCLES + 1);
    localparam logic [17:0] LAST_IDX = LENGTH - 18'd1;

    loader_state_t state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [17:0] byte_cnt_q, byte_cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wr_act_q, wr_act_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic        wren_q, wren_d;
    logic        shift_load, shift_en, shift_tx_en, bit_done;
    logic [7:0]  rx_byte;

    assign shift_en    = (state_q == ST_CMD) || (state_q == ST_DATA);
    assign shift_tx_en = (state_q == ST_CMD);

    spi_byte_shifter u_shifter (
        .clk_i       (clk28),
        .rst_ni      (rst_n),
        .en_i        (shift_en),
        .load_i      (shift_load),
        .load_data_i ({FLASH_CMD_READ, ROM_OFFSET}),
        .tx_en_i     (shift_tx_en),
        .miso_i      (flash_miso),
        .sck_o       (flash_sck),
        .mosi_o      (flash_mosi),
        .bit_done_o  (bit_done),
        .rx_byte_o   (rx_byte)
    );

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bitcnt_q   <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_act_q   <= 1'b0;
            wr_cnt_q   <= '0;
            wren_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bitcnt_q   <= bitcnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_act_q   <= wr_act_d;
            wr_cnt_q   <= wr_cnt_d;
            wren_q     <= wren_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = done_q;
        bitcnt_d   = bitcnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_act_d   = wr_act_q;
        wr_cnt_d   = wr_cnt_q;
        wren_d     = 1'b0;
        shift_load = 1'b0;

        // Write sequencer: cnt 0 setup, 1..WRC strobe, WRC+1 hold, then advance address.
        if (wr_act_q) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            wren_d   = (wr_cnt_q < WRC);
            if (wr_cnt_q == WR_END) begin
                wr_act_d = 1'b0;
                wr_cnt_d = '0;
                addr_d   = addr_q + 17'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (init && LENGTH != 18'd0) begin
                    state_d    = ST_CMD;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    shift_load = 1'b1;
                    bitcnt_d   = '0;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                end else if (LENGTH == 18'd0) begin
                    done_d = init;
                end
            end
            ST_CMD: begin
                if (bit_done) begin
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd31) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q[2:0] == 3'd7) begin
                        data_d     = rx_byte;
                        wr_act_d   = 1'b1;
                        wr_cnt_d   = '0;
                        byte_cnt_d = byte_cnt_q + 18'd1;
                        if (byte_cnt_q == LAST_IDX) state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_act_q && wr_cnt_q == WR_END) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign flash_cs_n  = cs_n_q;
    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign ram_wren    = wren_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_flash_rom_loader.sv
// Directed bench: flash model + SRAM write monitor around a LENGTH=4 and a LENGTH=0 loader.
module tb_flash_rom_loader;
    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    logic init  = 1'b0;
    logic initz = 1'b0;
    logic miso  = 1'b0;

    logic        cs_n, sck, mosi, wren, busy, done;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        z_cs_n, z_sck, z_mosi, z_wren, z_busy, z_done;
    logic [16:0] z_addr;
    logic [7:0]  z_data;

    always #5 clk28 = ~clk28;

    flash_rom_loader #(.ROM_OFFSET(24'h13256), .LENGTH(18'd4), .WR_CYCLES(4)) dut (
        .clk28(clk28), .rst_n(rst_n), .init(init),
        .flash_cs_n(cs_n), .flash_sck(sck), .flash_mosi(mosi), .flash_miso(miso),
        .ram_address(addr), .ram_data(data), .ram_wren(wren),
        .busy(busy), .done(done)
    );

    flash_rom_loader #(.ROM_OFFSET(24'h13256), .LENGTH(18'd0), .WR_CYCLES(4)) dut_z (
        .clk28(clk28), .rst_n(rst_n), .init(initz),
        .flash_cs_n(z_cs_n), .flash_sck(z_sck), .flash_mosi(z_mosi), .flash_miso(1'b0),
        .ram_address(z_addr), .ram_data(z_data), .ram_wren(z_wren),
        .busy(z_busy), .done(z_done)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash: capture the first 32 MOSI bits, then serve img[] MSB first on SCK falling edges.
    logic [7:0]  img [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    int          fcnt = 0;
    int          fb;
    logic [31:0] fcmd = '0;

    always @(posedge sck or posedge cs_n) begin
        if (cs_n) fcnt = 0;
        else begin
            if (fcnt < 32) fcmd = {fcmd[30:0], mosi};
            fcnt++;
        end
    end

    always @(negedge sck) begin
        if (!cs_n && fcnt >= 32) begin
            fb   = fcnt - 32;
            miso = img[(fb / 8) % 4][7 - (fb % 8)];
        end
    end

    // SRAM monitor: logs each write, its strobe length, and address/data stability around it.
    logic        pw = 1'b0;
    logic [16:0] pa = '0;
    logic [7:0]  pd = '0;
    int          len = 0, stab_err = 0, busy_cyc = 0;
    logic [16:0] wa [$];
    logic [7:0]  wd [$];
    int          wl [$];

    always @(negedge clk28) begin
        if (wren && !pw) begin
            if (addr !== pa || data !== pd) stab_err++;
            wa.push_back(addr);
            wd.push_back(data);
            len = 1;
        end else if (wren) begin
            len++;
            if (addr !== pa || data !== pd) stab_err++;
        end else if (pw) begin
            wl.push_back(len);
            if (addr !== pa || data !== pd) stab_err++;
        end
        pw = wren;
        pa = addr;
        pd = data;
        if (busy) busy_cyc++;
    end

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk28);
        chk(tag, busy, 1'b0);
    endtask

    task automatic check_copy(input string tag, input int b0, input int n0, input int l0, input int s0);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_cs"}, cs_n, 1'b1);
        chk({tag, "_sck"}, sck, 1'b0);
        #1;
        chk({tag, "_busy_cycles"}, 64'(busy_cyc - b0), 64'd135);
        chk({tag, "_cmd"}, fcmd, 32'h03013256);
        chk({tag, "_nwrites"}, 64'(wa.size() - n0), 64'd4);
        for (int i = 0; i < 4 && n0 + i < wa.size(); i++) begin
            chk({tag, "_write"}, {wa[n0+i], wd[n0+i]}, {17'(i), img[i]});
            if (l0 + i < wl.size()) chk({tag, "_wren_len"}, 64'(wl[l0+i]), 64'd4);
        end
        chk({tag, "_stable"}, 64'(stab_err - s0), 64'd0);
    endtask

    initial begin
        int b0, n0, l0, s0;
        repeat (3) @(negedge clk28);
        chk("rst_cs", cs_n, 1'b1);
        chk("rst_outs", {sck, mosi, wren, busy, done}, 5'b0);
        chk("rst_addr_data", {addr, data}, 25'd0);
        chk("rst_z", {z_cs_n, z_busy, z_done}, 3'b100);
        rst_n = 1'b1;
        @(negedge clk28);

        // Normal copy, checking command framing cycle by cycle at the start.
        b0 = busy_cyc; n0 = wa.size(); l0 = wl.size(); s0 = stab_err;
        init = 1'b1;
        @(negedge clk28);
        init = 1'b0;
        chk("start_cs_busy", {cs_n, busy}, 2'b01);
        chk("start_sck0", sck, 1'b0);
        @(negedge clk28);
        chk("setup_sck0", sck, 1'b0);
        chk("first_mosi", mosi, 1'b0);
        @(negedge clk28);
        chk("first_rise", sck, 1'b1);
        wait_idle("run1_timeout");
        check_copy("run1", b0, n0, l0, s0);

        // init re-asserted mid-copy must not restart the transfer.
        @(negedge clk28);
        b0 = busy_cyc; n0 = wa.size(); l0 = wl.size(); s0 = stab_err;
        init = 1'b1;
        @(negedge clk28);
        init = 1'b0;
        chk("restart_done_clr", {done, busy}, 2'b01);
        repeat (40) @(negedge clk28);
        init = 1'b1;
        repeat (2) @(negedge clk28);
        init = 1'b0;
        repeat (30) @(negedge clk28);
        init = 1'b1;
        @(negedge clk28);
        init = 1'b0;
        wait_idle("run2_timeout");
        check_copy("run2", b0, n0, l0, s0);

        // Reset during byte 2's write strobe, then a clean full copy.
        @(negedge clk28);
        init = 1'b1;
        @(negedge clk28);
        init = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk28);
            if (wren && addr == 17'd2) break;
        end
        chk("abort_point", {wren, addr}, {1'b1, 17'd2});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wren", wren, 1'b0);
        chk("abort_cs", {cs_n, sck, busy}, 3'b100);
        @(negedge clk28);
        rst_n = 1'b1;
        repeat (2) @(negedge clk28);
        b0 = busy_cyc; n0 = wa.size(); l0 = wl.size(); s0 = stab_err;
        init = 1'b1;
        @(negedge clk28);
        init = 1'b0;
        wait_idle("run3_timeout");
        check_copy("run3", b0, n0, l0, s0);

        // LENGTH=0: one-cycle done, never busy, CS stays high.
        @(negedge clk28);
        initz = 1'b1;
        @(negedge clk28);
        initz = 1'b0;
        chk("len0_done", {z_done, z_busy, z_cs_n}, 3'b101);
        @(negedge clk28);
        chk("len0_after", {z_done, z_busy, z_cs_n, z_sck}, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/flash_rom_loader.md
# flash_rom_loader

Boot-time memory initializer that streams ROM images from the configuration SPI flash directly into the external SRAM. On an `init` pulse it issues a single flash READ (0x03) at `ROM_OFFSET` and writes `LENGTH` consecutive bytes to SRAM addresses 0..LENGTH-1. While it runs, it owns the `va`/`vd`/`n_vwr` path through the memory controller. It replaces the rom2ram/asmi pair and feeds the top-level VA/VD muxes, in the same way `rom2ram_ram_wren` does.

## Interface
Parameters:
- `ROM_OFFSET`, 24'h13256: flash byte address of the first ROM byte.
- `LENGTH`, 18'h20000: number of bytes to copy (0..131072).
- `WR_CYCLES`, 4: `ram_wren` pulse width in clk28 cycles (1..12).

Ports:
- `clk28` in 1: system clock, 28 MHz. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `init` in 1: start request, level-sampled in IDLE.
- `flash_cs_n` out 1: SPI chip select.
- `flash_sck` out 1: SPI clock at clk28/2, mode 0.
- `flash_mosi` out 1: command and address bits, MSB first.
- `flash_miso` in 1: flash data, sampled on the SCK rising edge.
- `ram_address` out 17: SRAM byte address, which the top level maps to va[16:0].
- `ram_data` out 8: byte to write to vd.
- `ram_wren` out 1: SRAM write strobe. The top level drives `n_vwr` low while this is high.
- `busy` out 1: high from start until completion. It gates the CPU via init_done = !busy.
- `done` out 1: sticky completion flag.

## Operation
- All outputs reset to 0, except `flash_cs_n`, which resets to 1. State resets to IDLE.
- The states are IDLE, CMD, DATA, WRITE and FINISH.
- IDLE:
  - If `init`=1 and LENGTH≠0, go to CMD: `flash_cs_n`←0, `busy`←1, `done`←0, load the 32-bit shift register with {8'h03, ROM_OFFSET}, clear the bit counter.
  - If `init`=1 and LENGTH=0, set `done`←1 for one cycle only and stay in IDLE. `busy` stays 0.
- CMD:
  - The SCK phase toggles every clk28 cycle.
  - MOSI updates while SCK is low, one cycle before each rising edge.
  - After the 32nd rising edge, go to DATA. `flash_mosi` is held at 0 from then on.
- DATA:
  - On each SCK rising edge, shift `flash_miso` into an 8-bit register.
  - After the 8th bit, latch the byte into `ram_data` and start a write.
  - The SPI stream keeps running without stalling.
- Write sub-sequence, run in parallel with DATA:
  - Cycle 0: `ram_address` and `ram_data` become valid.
  - Cycles 1..WR_CYCLES: `ram_wren`=1.
  - Cycle WR_CYCLES+1: `ram_wren`=0 with address and data still held.
  - After that, `ram_address` increments (17-bit, wraps 0x1FFFF→0).
  - The whole sequence (WR_CYCLES+2 ≤ 14) always finishes within the 16-cycle byte time, so writes never overlap.
- Completion:
  - After the final byte's write sequence ends, go to FINISH.
  - FINISH sets `flash_cs_n`←1, `sck`←0, `busy`←0 and `done`←1, then returns to IDLE.
- `init` while busy is ignored. `init` held high after completion restarts a copy.
- When `rst_n` is asserted mid-transfer, all outputs return to their reset values immediately, which aborts the flash read. A partial SRAM image is acceptable because the next `init` rewrites it.

## Timing
- `init` is sampled at edge k.
  - `flash_cs_n`=0 and `busy`=1 from k+1.
  - The first SCK rising edge is at k+2, which gives ≥1 cycle of CS setup.
- Each bit takes 2 cycles. Each byte takes 16 cycles.
- Last data bit of byte n at edge t:
  - `ram_data` valid at t+1.
  - `ram_wren` high from t+2 to t+1+WR_CYCLES.
  - `ram_wren` low at t+2+WR_CYCLES.
- Total busy time is 1 + 64 + 16·LENGTH + WR_CYCLES + 2 cycles. For the defaults (LENGTH=131072, WR_CYCLES=4) that is 2097223 cycles, about 74.9 ms.
- `flash_sck` is low whenever `flash_cs_n`=1.

## Structure
- A shared package (`common`) holds:
  - `loader_state_t`, the enum of the five states.
  - `FLASH_CMD_READ` = 8'h03.
- A separate sub-module `spi_byte_shifter` (mode 0, clk28/2, 8- or 32-bit shift with a `bit_done` strobe) is natural. The FSM, address counter and write sequencer stay in `flash_rom_loader`.
- The top level drops `rom2ram_init` and `asmi`. It connects `busy` to init_done = !busy, and `ram_wren`/`ram_address`/`ram_data` into the existing VA/VD muxes.

## Test plan
- Command check:
  - Stimulus: reset, then `init` pulse, with a flash model.
  - Response: first 32 MOSI bits are 0x03, 0x01, 0x32, 0x56. CS low ≥1 cycle before the first SCK rise.
- Data copy:
  - Stimulus: LENGTH=4, flash returns A5, 3C, FF, 00.
  - Response: SRAM writes 0→A5, 1→3C, 2→FF, 3→00. Each `ram_wren` lasts exactly 4 cycles, and address/data are stable one cycle before and one cycle after it.
- Latency:
  - Stimulus: LENGTH=4, WR_CYCLES=4.
  - Response: `busy` high for exactly 1+64+64+6 = 135 cycles. `done`=1 on the cycle `busy` falls, and `flash_cs_n`=1.
- LENGTH=0:
  - Stimulus: `init` pulse with LENGTH=0.
  - Response: `busy` never rises, CS stays high, `done`=1.
- Ignored init:
  - Stimulus: `init` re-asserted mid-copy.
  - Response: no restart. The byte count and addresses are unchanged.
- Reset mid-transfer:
  - Stimulus: `rst_n` low during byte 2's `ram_wren`.
  - Response: `ram_wren`=0 and `flash_cs_n`=1 asynchronously. A subsequent `init` performs a full, correct copy starting at address 0.
